// File: rtl/fir_filter_seq_mac.sv
// fir_filter_seq_mac: TAPS-tap FIR filter built around a single time-multiplexed
// signed MAC. Runtime-loadable coefficients, valid/ready on both sides,
// arithmetic output scaling by OUT_SHIFT and output narrowing to OUT_WIDTH.
// Optional macro FIR_FILTER_SATURATE_EN: clamp to the OUT_WIDTH signed range and
// flag out_sat; without it the output wraps and out_sat is tied low.
module fir_filter_seq_mac #(
    parameter int DATA_WIDTH  = 8,
    parameter int COEFF_WIDTH = 8,
    parameter int TAPS        = 4,
    parameter int OUT_SHIFT   = 0,
    parameter int OUT_WIDTH   = 18,
    localparam int ACC_W      = DATA_WIDTH + COEFF_WIDTH + $clog2(TAPS),
    localparam int IDX_W      = ($clog2(TAPS) > 1) ? $clog2(TAPS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [DATA_WIDTH-1:0]  in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic signed [OUT_WIDTH-1:0]   out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_sat,
    input  logic                          coeff_wr_en,
    input  logic [IDX_W-1:0]              coeff_addr,
    input  logic signed [COEFF_WIDTH-1:0] coeff_data,
    output logic                          busy
);

    localparam int PROD_W = DATA_WIDTH + COEFF_WIDTH;
    localparam int WIDE_W = (ACC_W > OUT_WIDTH) ? ACC_W : OUT_WIDTH;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                        state, state_next;
    logic signed [DATA_WIDTH-1:0]  x     [TAPS];
    logic signed [COEFF_WIDTH-1:0] coeff [TAPS];
    logic signed [ACC_W-1:0]       acc;
    logic [IDX_W-1:0]              idx;
    logic signed [PROD_W-1:0]      prod;
    logic signed [ACC_W-1:0]       sum;
    logic signed [ACC_W-1:0]       scaled;
    logic signed [WIDE_W-1:0]      scaled_wide;
    logic                          last_tap;

    // Sign-extend (or pass through) the scaled sum so range checks and
    // narrowing work for any OUT_WIDTH relative to ACC_W.
    function automatic logic signed [WIDE_W-1:0] widen(input logic signed [ACC_W-1:0] v);
        return WIDE_W'(v);
    endfunction

`ifdef FIR_FILTER_SATURATE_EN
    localparam logic signed [WIDE_W-1:0] OUT_MAX = WIDE_W'({1'b0, {(OUT_WIDTH-1){1'b1}}});
    localparam logic signed [WIDE_W-1:0] OUT_MIN = -OUT_MAX - WIDE_W'(1);

    function automatic logic sat_hit(input logic signed [WIDE_W-1:0] v);
        return (v > OUT_MAX) || (v < OUT_MIN);
    endfunction

    function automatic logic signed [OUT_WIDTH-1:0] clamp(input logic signed [WIDE_W-1:0] v);
        if (v > OUT_MAX) return OUT_MAX[OUT_WIDTH-1:0];
        if (v < OUT_MIN) return OUT_MIN[OUT_WIDTH-1:0];
        return v[OUT_WIDTH-1:0];
    endfunction
`else
    function automatic logic signed [OUT_WIDTH-1:0] wrap(input logic signed [WIDE_W-1:0] v);
        return v[OUT_WIDTH-1:0];
    endfunction
`endif

    // MAC datapath: one full-width product per cycle added into the accumulator.
    always_comb begin
        prod        = PROD_W'(x[idx]) * PROD_W'(coeff[idx]);
        sum         = acc + ACC_W'(prod);
        scaled      = sum >>> OUT_SHIFT;
        scaled_wide = widen(scaled);
        last_tap    = (idx == IDX_W'(TAPS - 1));
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_next = MAC;
            end
            MAC: begin
                if (last_tap) state_next = OUT;
            end
            OUT: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Delay line, accumulator and tap index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) x[i] <= '0;
            acc <= '0;
            idx <= '0;
        end else if (state == IDLE && in_valid) begin
            x[0] <= in_data;
            for (int i = 1; i < TAPS; i++) x[i] <= x[i-1];
            acc <= '0;
            idx <= '0;
        end else if (state == MAC) begin
            acc <= sum;
            idx <= idx + IDX_W'(1);
        end
    end

    // Coefficient bank; writes land only while idle, so a write on the
    // acceptance edge is already visible to that sample's MAC pass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) coeff[i] <= (i == 0) ? COEFF_WIDTH'(1) : '0;
        end else if (state == IDLE && coeff_wr_en && int'(coeff_addr) < TAPS) begin
            coeff[coeff_addr] <= coeff_data;
        end
    end

    // Output stage: loaded on the last MAC edge, held until the consumer takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
`ifdef FIR_FILTER_SATURATE_EN
            out_sat   <= 1'b0;
`endif
        end else if (state == MAC && last_tap) begin
            out_valid <= 1'b1;
`ifdef FIR_FILTER_SATURATE_EN
            out_data  <= clamp(scaled_wide);
            out_sat   <= sat_hit(scaled_wide);
`else
            out_data  <= wrap(scaled_wide);
`endif
        end else if (state == OUT && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifndef FIR_FILTER_SATURATE_EN
    assign out_sat = 1'b0;
`endif

endmodule

// File: tb/tb_fir_filter_seq_mac.sv
// Directed bench for fir_filter_seq_mac: table of samples with hand-computed
// filter outputs, plus sequences for backpressure, coefficient-write timing,
// output narrowing and mid-operation reset.
module tb_fir_filter_seq_mac;

    logic               clk;
    logic               rst;
    logic signed [7:0]  in_data;
    logic               in_valid;
    logic               in_ready;
    logic signed [17:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic               out_sat;
    logic               coeff_wr_en;
    logic [1:0]         coeff_addr;
    logic signed [7:0]  coeff_data;
    logic               busy;

    logic               n_in_ready;
    logic signed [7:0]  n_out_data;
    logic               n_out_valid;
    logic               n_out_sat;
    logic               n_busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic signed [7:0] n_data_last;
    logic              n_sat_last;

    fir_filter_seq_mac dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_sat(out_sat),
        .coeff_wr_en(coeff_wr_en), .coeff_addr(coeff_addr), .coeff_data(coeff_data), .busy(busy)
    );

    // Narrow-output instance driven in lockstep with the main one.
    fir_filter_seq_mac #(.OUT_WIDTH(8)) dut_narrow (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(n_in_ready),
        .out_data(n_out_data), .out_valid(n_out_valid), .out_ready(out_ready), .out_sat(n_out_sat),
        .coeff_wr_en(coeff_wr_en), .coeff_addr(coeff_addr), .coeff_data(coeff_data), .busy(n_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic              do_rst;
        int                load;     // 0 keep, 1 ramp 1..4, 2 all 127
        logic signed [7:0] din;
        longint            expv;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input longint act, input longint expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic write_coeff(input logic [1:0] a, input logic signed [7:0] d);
        @(negedge clk);
        coeff_wr_en = 1'b1;
        coeff_addr  = a;
        coeff_data  = d;
        @(posedge clk);
        #1 coeff_wr_en = 1'b0;
    endtask

    // Waits for the result (lat0 edges already elapsed since acceptance),
    // checks it, then completes one output handshake.
    task automatic finish_out(input int lat0, input longint expv, input string nm);
        int lat;
        lat = lat0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({nm, "_latency"}, lat, 4);
        chk({nm, "_data"}, out_data, expv);
        chk({nm, "_sat"}, out_sat, 0);
        n_data_last = n_out_data;
        n_sat_last  = n_out_sat;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk({nm, "_valid_clr"}, out_valid, 0);
        chk({nm, "_idle"}, busy, 0);
    endtask

    task automatic send(input logic signed [7:0] d, input longint expv, input string nm);
        @(negedge clk);
        chk({nm, "_in_ready"}, in_ready, 1);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        finish_out(0, expv, nm);
    endtask

    initial begin
        longint exp_n;
        longint exp_ns;

        vecs[0]  = '{1'b1, 0, 8'sd5,   5};
        vecs[1]  = '{1'b0, 0, -8'sd3,  -3};
        vecs[2]  = '{1'b1, 1, 8'sd1,   1};
        vecs[3]  = '{1'b0, 0, 8'sd0,   2};
        vecs[4]  = '{1'b0, 0, 8'sd0,   3};
        vecs[5]  = '{1'b0, 0, 8'sd0,   4};
        vecs[6]  = '{1'b1, 1, 8'sd10,  10};
        vecs[7]  = '{1'b0, 0, 8'sd10,  30};
        vecs[8]  = '{1'b0, 0, 8'sd10,  60};
        vecs[9]  = '{1'b0, 0, 8'sd10,  100};
        vecs[10] = '{1'b1, 2, 8'sd127, 16129};
        vecs[11] = '{1'b0, 0, 8'sd127, 32258};
        vecs[12] = '{1'b0, 0, 8'sd127, 48387};
        vecs[13] = '{1'b0, 0, 8'sd127, 64516};

        rst = 1'b1;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        coeff_wr_en = 1'b0; coeff_addr = '0; coeff_data = '0;
        n_data_last = '0; n_sat_last = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].do_rst) do_reset();
            if (vecs[i].load == 1) begin
                for (int k = 0; k < 4; k++) write_coeff(2'(k), 8'(k + 1));
            end else if (vecs[i].load == 2) begin
                for (int k = 0; k < 4; k++) write_coeff(2'(k), 8'sd127);
            end
            send(vecs[i].din, vecs[i].expv, $sformatf("vec%0d", i));
        end

`ifdef FIR_FILTER_SATURATE_EN
        exp_n  = 127;
        exp_ns = 1;
`else
        exp_n  = 4;
        exp_ns = 0;
`endif
        chk("narrow_data", n_data_last, exp_n);
        chk("narrow_sat", n_sat_last, exp_ns);

        // Backpressure: result held while the consumer stalls.
        do_reset();
        @(negedge clk);
        in_data = 8'sd9;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_valid_rise", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_data_hold", out_data, 9);
            chk("bp_valid_hold", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_busy", busy, 1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("bp_valid_clr", out_valid, 0);
        chk("bp_busy_clr", busy, 0);
        chk("bp_in_ready_back", in_ready, 1);
        chk("bp_data_kept", out_data, 9);

        // Coefficient write during MAC is dropped.
        do_reset();
        @(negedge clk);
        in_data = 8'sd6;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("macwr_busy", busy, 1);
        coeff_wr_en = 1'b1;
        coeff_addr  = 2'd0;
        coeff_data  = 8'sd3;
        @(posedge clk);
        #1 coeff_wr_en = 1'b0;
        finish_out(1, 6, "macwr");

        // Same write in IDLE takes effect: x = {5,6,0,0}, c = {3,0,0,0}.
        write_coeff(2'd0, 8'sd3);
        send(8'sd5, 15, "idlewr");

        // Write on the acceptance edge is used: x = {4,5,6,0}, c = {3,2,0,0}.
        @(negedge clk);
        in_data     = 8'sd4;
        in_valid    = 1'b1;
        coeff_wr_en = 1'b1;
        coeff_addr  = 2'd1;
        coeff_data  = 8'sd2;
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        coeff_wr_en = 1'b0;
        finish_out(0, 22, "samewr");

        // Reset mid-MAC discards the result and restores default coefficients.
        @(negedge clk);
        in_data = 8'sd3;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_busy_before", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_data", out_data, 0);
        @(negedge clk);
        rst = 1'b0;
        send(8'sd7, 7, "postrst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
